// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional feature macro: LSU_MISALIGNED_EN (split misaligned accesses into byte beats).
package lsu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  // FSM state encoding
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  // Number of memory beats for a request; 0 means the request is rejected.
  function automatic logic [2:0] beat_count(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [2:0] n;
    n = 3'd0;
    case (funct3)
      LSU_B, LSU_BU: n = 3'd1;
      LSU_H, LSU_HU: begin
`ifdef LSU_MISALIGNED_EN
        n = 3'd2;
`else
        n = addr_lo[0] ? 3'd0 : 3'd2;
`endif
      end
      LSU_W: begin
`ifdef LSU_MISALIGNED_EN
        n = (addr_lo == 2'b00) ? 3'd1 : 3'd4;
`else
        n = (addr_lo == 2'b00) ? 3'd1 : 3'd0;
`endif
      end
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side bus of the load/store unit.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  mem_byte_op;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  // LSU side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_we, mem_byte_op, mem_wd
  );

  // Pipeline + memory side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_we, mem_byte_op, mem_wd
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load byte assembly register plus sign/zero extension of the assembled value.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  capture_i,
  input  logic                  word_i,
  input  logic [1:0]            beat_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rd_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] asm_q, asm_d;

  // Merge the current beat into the assembly register (little-endian byte k at bits 8k+7:8k)
  always_comb begin
    asm_d = asm_q;
    if (clear_i) begin
      asm_d = '0;
    end else if (capture_i) begin
      if (word_i) begin
        asm_d = rd_i;
      end else begin
        asm_d[{beat_i, 3'b000} +: BYTE_WIDTH] = rd_i[BYTE_WIDTH-1:0];
      end
    end
  end

  // Extension works on the next-state value so the final beat is included
  always_comb begin
    case (funct3_i)
      LSU_B:   data_o = {{24{asm_d[7]}}, asm_d[7:0]};
      LSU_BU:  data_o = {24'h0, asm_d[7:0]};
      LSU_H:   data_o = {{16{asm_d[15]}}, asm_d[15:0]};
      LSU_HU:  data_o = {16'h0, asm_d[15:0]};
      default: data_o = asm_d;
    endcase
  end

  // Assembly register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_q <= '0;
    end else begin
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RISC-V load/store initiator towards a word/byte memory.
// Optional feature macro: LSU_MISALIGNED_EN (see lsu_pkg::beat_count).
module load_store_unit
  import lsu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  load_store_unit_if.slave bus_io
);

  logic [1:0]            state_q, state_d;
  logic [1:0]            beat_q, beat_d;
  logic [2:0]            nbeats_q, nbeats_d;
  logic                  we_q, we_d;
  logic                  word_q, word_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  last_beat;
  logic [2:0]            req_beats;
  logic [DATA_WIDTH-1:0] load_data;

  assign accept    = (state_q == StIdle) && bus_io.req_valid;
  assign req_beats = beat_count(bus_io.req_funct3, bus_io.req_addr[1:0]);
  assign last_beat = (state_q == StAccess) && ({1'b0, beat_q} == nbeats_q - 3'd1);

  lsu_load_align u_load_align (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (accept),
    .capture_i ((state_q == StAccess) && !we_q),
    .word_i    (word_q),
    .beat_i    (beat_q),
    .funct3_i  (funct3_q),
    .rd_i      (bus_io.mem_rd),
    .data_o    (load_data)
  );

  // FSM and request latching
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    nbeats_d = nbeats_q;
    we_d     = we_q;
    word_d   = word_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d     = bus_io.req_we;
          funct3_d = bus_io.req_funct3;
          addr_d   = bus_io.req_addr;
          wdata_d  = bus_io.req_wdata;
          nbeats_d = req_beats;
          word_d   = (bus_io.req_funct3 == LSU_W) && (bus_io.req_addr[1:0] == 2'b00);
          beat_d   = 2'd0;
          if (req_beats == 3'd0) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        beat_d = beat_q + 2'd1;
        if (last_beat) begin
          state_d = StResp;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : load_data;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory beat drive; everything idles at zero outside ACCESS
  always_comb begin
    bus_io.mem_addr    = '0;
    bus_io.mem_we      = 1'b0;
    bus_io.mem_byte_op = 1'b0;
    bus_io.mem_wd      = '0;
    if (state_q == StAccess) begin
      bus_io.mem_addr    = addr_q + {30'h0, beat_q};
      bus_io.mem_we      = we_q;
      bus_io.mem_byte_op = !word_q;
      bus_io.mem_wd      = word_q ? wdata_q : {24'h0, wdata_q[{beat_q, 3'b000} +: BYTE_WIDTH]};
    end
  end

  assign bus_io.req_ready  = (state_q == StIdle);
  assign bus_io.resp_valid = (state_q == StResp);
  assign bus_io.resp_rdata = rdata_q;
  assign bus_io.resp_err   = err_q;

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      beat_q   <= 2'd0;
      nbeats_q <= 3'd0;
      we_q     <= 1'b0;
      word_q   <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      nbeats_q <= nbeats_d;
      we_q     <= we_d;
      word_q   <= word_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a byte-array memory.
module tb_load_store_unit;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic load_img;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0]  mem     [64];
  logic [7:0]  ref_mem [64];
  logic [5:0]  mix;
  logic [31:0] last_rdata;
  logic        last_err;
  logic        last_we_seen;

  always #5 clk_i = ~clk_i;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  // Combinational read port of the data memory
  assign mix = bus.mem_addr[5:0];
  always_comb begin
    bus.mem_rd = {24'h0, mem[mix]};
    if (!bus.mem_byte_op) begin
      bus.mem_rd = {mem[mix + 6'd3], mem[mix + 6'd2], mem[mix + 6'd1], mem[mix]};
    end
  end

  // Writes commit on the falling edge
  always @(negedge clk_i) begin
    if (load_img) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_we) begin
      if (bus.mem_byte_op) begin
        mem[mix] <= bus.mem_wd[7:0];
      end else begin
        for (int i = 0; i < 4; i++) mem[mix + 6'(i)] <= bus.mem_wd[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Request-level reference: access size and alignment decide everything
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output int lat, output int beats, output logic word);
    int size;
    logic mis;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    err = (size == 0);
    mis = (size > 1) && ((a % size) != 0);
`ifndef LSU_MISALIGNED_EN
    if (mis) err = 1'b1;
`endif
    rd = 32'h0;
    word = 1'b0;
    if (err) begin
      lat = 1;
      beats = 0;
    end else begin
      word  = (size == 4) && !mis;
      beats = word ? 1 : size;
      lat   = beats + 1;
      v = 32'h0;
      for (int i = 0; i < size; i++) begin
        if (we) ref_mem[(a + i) % 64] = wd[8*i +: 8];
        else v = v | (32'(ref_mem[(a + i) % 64]) << (8 * i));
      end
      if (!we) begin
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    logic exp_err, exp_word, got, saw_word, saw_we;
    logic [31:0] exp_rd;
    int exp_lat, exp_beats, cyc, beats;
    model(we, f3, a, wd, exp_err, exp_rd, exp_lat, exp_beats, exp_word);
    @(negedge clk_i);
    check("ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk_i);
    #1 bus.req_valid = 1'b0;
    cyc = 0; beats = 0; got = 1'b0; saw_word = 1'b0; saw_we = 1'b0;
    while (!got && cyc < 20) begin
      cyc++;
      @(negedge clk_i);
      if (bus.resp_valid) begin
        got = 1'b1;
      end else if (bus.mem_addr != 32'h0) begin
        beats++;
        if (!bus.mem_byte_op) saw_word = 1'b1;
        if (bus.mem_we) saw_we = 1'b1;
      end
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("err", 32'(bus.resp_err), 32'(exp_err));
    check("rdata", bus.resp_rdata, exp_rd);
    check("beats", 32'(beats), 32'(exp_beats));
    check("word_beat", 32'(saw_word), 32'(exp_word));
    last_rdata   = bus.resp_rdata;
    last_err     = bus.resp_err;
    last_we_seen = saw_we;
  endtask

  initial begin
    rst_ni = 1'b0;
    load_img = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
    ref_mem[0] = 8'h80; ref_mem[1] = 8'h7F; ref_mem[2] = 8'h01;
    ref_mem[3] = 8'hFF; ref_mem[4] = 8'h00;
    repeat (2) @(negedge clk_i);
    load_img = 1'b0;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    check("rst_err", 32'(bus.resp_err), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_ctl", {30'h0, bus.mem_we, bus.mem_byte_op}, 32'h0);
    check("rst_mem_wd", bus.mem_wd, 32'h0);
    rst_ni = 1'b1;

    do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0);
    check("lw_const", last_rdata, 32'hFF01_7F80);
    do_req(1'b0, 3'b000, 32'h0001_0000, 32'h0);
    check("lb_const", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h0001_0000, 32'h0);
    check("lbu_const", last_rdata, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h0001_0002, 32'h0);
    check("lh_const", last_rdata, 32'hFFFF_FF01);
    do_req(1'b0, 3'b101, 32'h0001_0002, 32'h0);
    check("lhu_const", last_rdata, 32'h0000_FF01);
    do_req(1'b0, 3'b010, 32'h0001_0001, 32'h0);
`ifdef LSU_MISALIGNED_EN
    check("lw_mis_const", last_rdata, 32'h00FF_017F);
`else
    check("lw_mis_err", 32'(last_err), 32'd1);
    check("lw_mis_no_we", 32'(last_we_seen), 32'd0);
`endif
    do_req(1'b0, 3'b011, 32'h0001_0000, 32'h0);
    check("illegal_err", 32'(last_err), 32'd1);
    do_req(1'b1, 3'b001, 32'h0001_0001, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0);
`ifdef LSU_MISALIGNED_EN
    check("sh_then_lw", last_rdata, 32'hFFBE_EF80);
`endif

    for (int n = 0; n < 80; n++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      do_req(1'($urandom), f3, 32'h0001_0000 + 32'($urandom_range(0, 31)), $urandom);
    end

`ifdef LSU_MISALIGNED_EN
    // Reset lands in beat 2 of a misaligned store, before its falling edge
    @(negedge clk_i);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0001_0011;
    bus.req_wdata  = 32'hA1B2_C3D4;
    @(posedge clk_i);
    #1 bus.req_valid = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_we", 32'(bus.mem_we), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("rst_mid_b0", 32'(mem[6'h11]), 32'h0000_00D4);
    check("rst_mid_b1", 32'(mem[6'h12]), 32'h0000_00C3);
    check("rst_mid_b2", 32'(mem[6'h13]), 32'(ref_mem[6'h13]));
    ref_mem[6'h11] = 8'hD4;
    ref_mem[6'h12] = 8'hC3;
    do_req(1'b0, 3'b010, 32'h0001_0010, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
